// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and parameter sanity check.
//   bin2gray(b, w)      : binary -> Gray over the low w bits
//   gray2bin(g, w)      : Gray -> binary over the low w bits
//   params_bad(w, max)  : 1 when WIDTH/MAX are outside the legal range
package gray_pkg;

   function automatic logic [31:0] width_mask(input int unsigned w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return m[31:0];
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
      logic [31:0] bm;
      bm = b & width_mask(w);
      return bm ^ (bm >> 1);
   endfunction

   // Upper bits are masked to zero, so a prefix XOR from bit 31 down
   // is identical to decoding from bit w-1 down.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
      logic [31:0] gm;
      logic [31:0] r;
      gm = g & width_mask(w);
      r = '0;
      r[31] = gm[31];
      for (int i = 30; i >= 0; i--) begin
         r[i] = r[i+1] ^ gm[i];
      end
      return r;
   endfunction

   function automatic bit params_bad(input int unsigned w, input longint unsigned max);
      return (w < 2) || (w > 32) || (max < 1) || (max > ((64'd1 << w) - 64'd1));
   endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray -> binary decoder (prefix XOR from the MSB).
//   i_gray : Gray-coded input, WIDTH bits
//   o_bin  : binary result, WIDTH bits
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   logic [WIDTH-1:0] w_acc;

   always_comb begin
      w_acc = '0;
      w_acc[WIDTH-1] = i_gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         w_acc[i] = w_acc[i+1] ^ i_gray[i];
      end
      o_bin = w_acc;
   end

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down modulo-(MAX+1) counter with registered binary and
// Gray outputs, parallel load (binary or Gray), load range check and a
// combinational terminal count for cascading digits.
//   clk, rst_n          : clock, synchronous active-low reset
//   en, up              : count enable, direction (1 = up)
//   load, load_gray     : load strobe (wins over en), load_val format
//   load_val            : value to load
//   bin, gray           : registered count in binary and Gray
//   tc                  : terminal count, drives the next digit's en
//   err                 : one-cycle pulse after a load above MAX
// With MAX < 2^WIDTH-1 the MAX<->0 wrap may flip more than one Gray bit.
module gray_counter
   import gray_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter int unsigned MAX   = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             tc,
   output logic             err
);

   localparam bit               P_BAD = params_bad(WIDTH, 64'(MAX));
   localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

   generate
      if (P_BAD) begin : g_bad_params
         $error("gray_counter: illegal WIDTH/MAX combination");
      end
   endgenerate

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_err;

   logic [WIDTH-1:0] w_dec;
   logic [WIDTH-1:0] w_load_bin;
   logic [WIDTH-1:0] w_load_gray;
   logic             w_load_ok;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_next_gray;
   logic             w_at_max;
   logic             w_at_zero;

   gray2bin #(.WIDTH(WIDTH)) u_dec (
      .i_gray (load_val),
      .o_bin  (w_dec)
   );

   assign w_load_bin  = load_gray ? w_dec : load_val;
   assign w_load_ok   = (w_load_bin <= MAX_V);
   assign w_load_gray = WIDTH'(bin2gray(32'(w_load_bin), WIDTH));

   assign w_at_max  = (r_bin == MAX_V);
   assign w_at_zero = (r_bin == '0);

   always_comb begin
      w_next = r_bin;
      if (up) begin
         w_next = w_at_max ? '0 : r_bin + 1'b1;
      end else begin
         w_next = w_at_zero ? MAX_V : r_bin - 1'b1;
      end
   end

   assign w_next_gray = WIDTH'(bin2gray(32'(w_next), WIDTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (load) begin
            if (w_load_ok) begin
               r_bin  <= w_load_bin;
               r_gray <= w_load_gray;
            end else begin
               r_err <= 1'b1;
            end
         end else if (en) begin
            r_bin  <= w_next;
            r_gray <= w_next_gray;
         end
      end
   end

   assign tc   = en & ~load & ((up & w_at_max) | (~up & w_at_zero));
   assign bin  = r_bin;
   assign gray = r_gray;
   assign err  = r_err;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en, up, load, load_gray;
   logic [3:0] load_val;
   logic [3:0] bin, gray;
   logic       tc, err;

   logic       f_en;
   logic [3:0] f_bin, f_gray;
   logic       f_tc, f_err;

   logic       c_en;
   logic [3:0] lo_bin, lo_gray, hi_bin, hi_gray;
   logic       lo_tc, lo_err, hi_tc, hi_err;

   int n_total = 0;
   int n_bad   = 0;

   gray_counter #(.WIDTH(4), .MAX(9)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_gray(load_gray), .load_val(load_val),
      .bin(bin), .gray(gray), .tc(tc), .err(err)
   );

   gray_counter #(.WIDTH(4), .MAX(15)) u_full (
      .clk(clk), .rst_n(rst_n), .en(f_en), .up(1'b1), .load(1'b0),
      .load_gray(1'b0), .load_val(4'd0),
      .bin(f_bin), .gray(f_gray), .tc(f_tc), .err(f_err)
   );

   gray_counter #(.WIDTH(4), .MAX(9)) u_lo (
      .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .load(1'b0),
      .load_gray(1'b0), .load_val(4'd0),
      .bin(lo_bin), .gray(lo_gray), .tc(lo_tc), .err(lo_err)
   );

   gray_counter #(.WIDTH(4), .MAX(9)) u_hi (
      .clk(clk), .rst_n(rst_n), .en(lo_tc), .up(1'b1), .load(1'b0),
      .load_gray(1'b0), .load_val(4'd0),
      .bin(hi_bin), .gray(hi_gray), .tc(hi_tc), .err(hi_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] up_bin  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
   logic [3:0] up_gray [12] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'h0, 4'h1, 4'h3};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] prev;
      logic [3:0] eg;

      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b1; load_gray = 1'b0; load_val = 4'd5;
      f_en = 1'b0; c_en = 1'b0;

      // reset wins over a pending load
      step();
      chk("rst_bin", 32'(bin), 0);
      chk("rst_gray", 32'(gray), 0);
      chk("rst_err", 32'(err), 0);

      en = 1'b1; up = 1'b0; load = 1'b0;
      #1;
      chk("rst_tc", 32'(tc), 1);
      step();
      chk("rst_hold_bin", 32'(bin), 0);

      // up count 12 steps
      rst_n = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("up_tc%0d", k), 32'(tc), (k == 9) ? 1 : 0);
         step();
         chk($sformatf("up_bin%0d", k), 32'(bin), 32'(up_bin[k]));
         chk($sformatf("up_gray%0d", k), 32'(gray), 32'(up_gray[k]));
      end

      // down count from 0
      rst_n = 1'b0; en = 1'b0;
      step();
      rst_n = 1'b1; en = 1'b1; up = 1'b0;
      #1;
      chk("dn_tc0", 32'(tc), 1);
      step();
      chk("dn_bin9", 32'(bin), 9);
      chk("dn_tc9", 32'(tc), 0);
      step();
      chk("dn_bin8", 32'(bin), 8);
      step();
      chk("dn_bin7", 32'(bin), 7);

      // Gray load of 0xD -> 9
      en = 1'b0; load = 1'b1; load_gray = 1'b1; load_val = 4'hD;
      step();
      chk("ldg_bin", 32'(bin), 9);
      chk("ldg_gray", 32'(gray), 32'h0D);
      chk("ldg_err", 32'(err), 0);

      // binary 12 rejected, with en asserted at count 9 (tc must stay 0)
      en = 1'b1; up = 1'b1; load_gray = 1'b0; load_val = 4'd12;
      #1;
      chk("ld_en_tc", 32'(tc), 0);
      step();
      chk("bad_bin", 32'(bin), 9);
      chk("bad_err", 32'(err), 1);

      load = 1'b0; en = 1'b0;
      #1;
      chk("hold_tc", 32'(tc), 0);
      step();
      chk("hold_bin", 32'(bin), 9);
      chk("hold_gray", 32'(gray), 32'h0D);
      chk("err_pulse_end", 32'(err), 0);

      en = 1'b1; up = 1'b1;
      #1;
      chk("max_tc", 32'(tc), 1);
      step();
      chk("wrap_bin", 32'(bin), 0);

      // load with en: load value taken, no count
      load = 1'b1; load_gray = 1'b0; load_val = 4'd3;
      step();
      chk("ld_en_bin", 32'(bin), 3);
      chk("ld_en_gray", 32'(gray), 2);
      chk("ld_en_err", 32'(err), 0);

      // Gray 0xF decodes to 10 > MAX
      load_gray = 1'b1; load_val = 4'hF; en = 1'b0;
      step();
      chk("badg_bin", 32'(bin), 3);
      chk("badg_err", 32'(err), 1);

      // reset together with a legal load
      rst_n = 1'b0; load_gray = 1'b0; load_val = 4'd5;
      step();
      chk("rst_ld_bin", 32'(bin), 0);
      chk("rst_ld_gray", 32'(gray), 0);
      chk("rst_ld_err", 32'(err), 0);
      rst_n = 1'b1; load = 1'b0; en = 1'b0;

      // full-range counter: single-bit Gray steps including wrap
      f_en = 1'b1;
      prev = f_gray;
      chk("full_start", 32'(f_bin), 0);
      for (int k = 0; k < 16; k++) begin
         step();
         eg = 4'((k + 1) % 16);
         chk($sformatf("full_bin%0d", k), 32'(f_bin), 32'(eg));
         eg = eg ^ (eg >> 1);
         chk($sformatf("full_gray%0d", k), 32'(f_gray), 32'(eg));
         chk($sformatf("full_1bit%0d", k), $countones(f_gray ^ prev), 1);
         prev = f_gray;
      end
      f_en = 1'b0;

      // two-digit BCD cascade 00..99 and back to 00
      c_en = 1'b1;
      chk("casc_start", 32'(hi_bin) * 10 + 32'(lo_bin), 0);
      for (int k = 0; k < 100; k++) begin
         step();
         chk($sformatf("casc%0d", k), 32'(hi_bin) * 10 + 32'(lo_bin), 32'((k + 1) % 100));
      end
      c_en = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter and output width in bits; legal range 2..32.
REQ-002 Parameter MAX, default 9: highest count value, in binary; legal range 1..2^WIDTH-1 (9 gives a BCD digit, 2^WIDTH-1 gives full binary range).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-007 load  input  1  parallel-load strobe; has priority over en.
REQ-008 load_gray  input  1  format of load_val: 1 = Gray coded, 0 = plain binary.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 bin  output  WIDTH  registered count, binary.
REQ-011 gray  output  WIDTH  registered count, Gray coded.
REQ-012 tc  output  1  terminal count, combinational, for cascading digits.
REQ-013 err  output  1  registered one-cycle pulse on a rejected load.

Function
REQ-014 Gray encoding shall be gray[WIDTH-1] = bin[WIDTH-1] and gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1.
REQ-015 bin and gray shall be updated in the same clock edge, with zero cycles of skew between them.
REQ-016 Priority per edge shall be: reset, then load, then en, then hold.
REQ-017 On load with load_gray=1, load_val shall be decoded as b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] XOR g[i].
REQ-018 On load, a decoded value <= MAX shall be written to the count, with err = 0 on the next cycle.
REQ-019 On load, a decoded value > MAX shall leave the count unchanged, and err = 1 for exactly the next cycle.
REQ-020 When en=1, up=1 and load=0: if count == MAX the count wraps to 0, otherwise it becomes count+1.
REQ-021 When en=1, up=0 and load=0: if count == 0 the count wraps to MAX, otherwise it becomes count-1.
REQ-022 When en=0 and load=0, the count shall hold and err shall be 0.
REQ-023 tc = en AND NOT load AND ((up AND count==MAX) OR (NOT up AND count==0)); the next digit's en is driven by tc.
REQ-024 Load and en asserted together: the load is taken, no count occurs, and tc = 0.
REQ-025 Single-bit Gray change per step is guaranteed only when MAX = 2^WIDTH-1.
REQ-026 For other MAX values, the wrap step MAX<->0 may change more than one bit; this is accepted and documented, not an error.
REQ-027 Latency shall be 1 cycle from a sampled load or en to the updated bin, gray and err.

Reset
REQ-028 While rst_n=0 at a clock edge: count = 0, bin = 0, gray = 0, err = 0, regardless of load, en and up.
REQ-029 tc follows REQ-023 with count = 0 (tc = 1 if en=1, up=0, load=0 during reset).
REQ-030 Reset asserted during a load or a count step shall win; the load value is discarded.
REQ-031 The first active edge after rst_n returns to 1 shall behave per REQ-016 from count 0.

Structure
REQ-032 Shared package gray_pkg shall hold functions bin2gray and gray2bin, parametrised by width.
REQ-033 gray_pkg shall also hold a parameter-check constant that flags MAX > 2^WIDTH-1 or WIDTH < 2 at elaboration.
REQ-034 One sub-module, gray2bin (combinational prefix-XOR decoder, WIDTH parameter), shall be instantiated on the load path.
REQ-035 The counter core, MAX compare and output registers shall be in gray_counter itself; no further hierarchy.

Verification
REQ-036 WIDTH=4, MAX=9: reset, then en=1, up=1 for 12 cycles -> bin 1..9,0,1,2; gray 1,3,2,6,7,5,4,C,D,0,1,3 (hex); tc=1 only in the cycle where bin=9.
REQ-037 WIDTH=4, MAX=9: from 0 with en=1, up=0 -> bin 9,8,7; tc=1 in the first cycle (count=0).
REQ-038 WIDTH=4, MAX=9: load=1, load_gray=1, load_val=0xD -> bin=9, gray=0xD, err=0.
REQ-039 WIDTH=4, MAX=9: load=1, load_gray=0, load_val=12 -> bin unchanged, err=1 for one cycle.
REQ-040 WIDTH=4, MAX=15: full up-count over 16 steps -> bin wraps 15->0, and every gray transition, including the wrap, changes exactly one bit.
REQ-041 Load and en in the same cycle -> load value taken; rst_n=0 together with load -> bin=0, gray=0, err=0; two gray_counter instances cascaded via tc count 00..99 correctly.
